// File: rtl/booth_pkg.sv
// Shared constants and sizing helpers for the radix-4 Booth operand encoder.
package booth_pkg;

    // Triplet codes, ordered as (b[2i+1], b[2i], b[2i-1]).
    localparam logic [2:0] TRIP_Z0  = 3'b000;
    localparam logic [2:0] TRIP_P1A = 3'b001;
    localparam logic [2:0] TRIP_P1B = 3'b010;
    localparam logic [2:0] TRIP_P2  = 3'b011;
    localparam logic [2:0] TRIP_N2  = 3'b100;
    localparam logic [2:0] TRIP_N1A = 3'b101;
    localparam logic [2:0] TRIP_N1B = 3'b110;
    localparam logic [2:0] TRIP_Z1  = 3'b111;

    // Digit patterns, ordered as {neg, two, one}. A zero digit never carries neg.
    localparam logic [2:0] DIG_ZERO = 3'b000;
    localparam logic [2:0] DIG_POS1 = 3'b001;
    localparam logic [2:0] DIG_POS2 = 3'b010;
    localparam logic [2:0] DIG_NEG1 = 3'b101;
    localparam logic [2:0] DIG_NEG2 = 3'b110;

    // One extra digit beyond WIDTH/2 so unsigned operands with the MSB set still fit.
    function automatic int ndig(input int width);
        return width / 2 + 1;
    endfunction

    // Width of a counter that can hold 0..nd inclusive.
    function automatic int nz_w(input int nd);
        return $clog2(nd + 1);
    endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Combinational decode of one Booth triplet into {one, two, neg} select lines.
module booth_r4_digit
    import booth_pkg::*;
(
    input  logic [2:0] trip_i,
    output logic       one_o,
    output logic       two_o,
    output logic       neg_o
);

    logic [2:0] pat;

    // Map the triplet onto its signed-magnitude digit pattern.
    always_comb begin
        pat = DIG_ZERO;
        case (trip_i)
            TRIP_Z0, TRIP_Z1:   pat = DIG_ZERO;
            TRIP_P1A, TRIP_P1B: pat = DIG_POS1;
            TRIP_P2:            pat = DIG_POS2;
            TRIP_N2:            pat = DIG_NEG2;
            TRIP_N1A, TRIP_N1B: pat = DIG_NEG1;
            default:            pat = DIG_ZERO;
        endcase
    end

    assign {neg_o, two_o, one_o} = pat;

endmodule

// File: rtl/booth_r4_encoder_pipe.sv
// Two-stage valid/ready pipeline that Booth-encodes a multiplier operand into
// NDIG radix-4 digits and counts the nonzero ones. WIDTH must be even and >= 4.
module booth_r4_encoder_pipe
    import booth_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    localparam int NDIG = ndig(WIDTH),
    localparam int NZW  = nz_w(NDIG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NDIG-1:0]  out_one,
    output logic [NDIG-1:0]  out_two,
    output logic [NDIG-1:0]  out_neg,
    output logic [NZW-1:0]   out_nz_cnt,
    output logic [TAG_W-1:0] out_tag
);

    // Stage 1: raw operand
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_data_q;
    logic             s1_signed_q;
    logic [TAG_W-1:0] s1_tag_q;

    // Stage 2: encoded digits
    logic             s2_valid_q;
    logic [NDIG-1:0]  s2_one_q;
    logic [NDIG-1:0]  s2_two_q;
    logic [NDIG-1:0]  s2_neg_q;
    logic [NZW-1:0]   s2_nz_q;
    logic [TAG_W-1:0] s2_tag_q;

    // Encoder results computed from stage 1
    logic [NDIG-1:0]  one_d;
    logic [NDIG-1:0]  two_d;
    logic [NDIG-1:0]  neg_d;
    logic [NZW-1:0]   nz_cnt_d;

    logic             s1_advance;
    logic             ext_msb;
    logic [WIDTH+2:0] ext_b;

    // S2 can take a new entry when it is empty or its current entry leaves this cycle.
    assign s1_advance = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s1_advance;

    // ext_b[j] holds b[j-1]: a zero below the LSB and two sign/zero bits above the MSB.
    assign ext_msb = s1_signed_q & s1_data_q[WIDTH-1];
    assign ext_b   = {ext_msb, ext_msb, s1_data_q, 1'b0};

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
        booth_r4_digit u_dig (
            .trip_i (ext_b[2*gi+2 -: 3]),
            .one_o  (one_d[gi]),
            .two_o  (two_d[gi]),
            .neg_o  (neg_d[gi])
        );
    end

    // Count digits with nonzero magnitude for partial-product row gating.
    always_comb begin
        nz_cnt_d = '0;
        for (int k = 0; k < NDIG; k++) begin
            nz_cnt_d = nz_cnt_d + NZW'(one_d[k] | two_d[k]);
        end
    end

    // Stage 1 capture: loads whenever it can accept, so a bubble propagates as invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_signed_q <= 1'b0;
            s1_tag_q    <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q   <= in_data;
                s1_signed_q <= in_signed;
                s1_tag_q    <= in_tag;
            end
        end
    end

    // Stage 2 capture: holds while the downstream stalls, otherwise takes S1's result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_one_q   <= '0;
            s2_two_q   <= '0;
            s2_neg_q   <= '0;
            s2_nz_q    <= '0;
            s2_tag_q   <= '0;
        end else if (s1_advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_one_q <= one_d;
                s2_two_q <= two_d;
                s2_neg_q <= neg_d;
                s2_nz_q  <= nz_cnt_d;
                s2_tag_q <= s1_tag_q;
            end
        end
    end

    // Stale payload is masked so idle outputs always read zero.
    assign out_valid  = s2_valid_q;
    assign out_one    = s2_valid_q ? s2_one_q : '0;
    assign out_two    = s2_valid_q ? s2_two_q : '0;
    assign out_neg    = s2_valid_q ? s2_neg_q : '0;
    assign out_nz_cnt = s2_valid_q ? s2_nz_q  : '0;
    assign out_tag    = s2_valid_q ? s2_tag_q : '0;

endmodule

// File: tb/tb_booth_r4_encoder_pipe.sv
// Bench for booth_r4_encoder_pipe: 16-bit directed/streaming/reset scenarios and
// randomized traffic on 8-, 16- and 32-bit instances, scored against a digit-value model.
module tb_booth_r4_encoder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   chk_lat = 1'b0;
    bit   rnd_on  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // 16-bit instance
    logic        a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready;
    logic [15:0] a_in_data;
    logic [3:0]  a_in_tag, a_out_tag, a_nz;
    logic [8:0]  a_one, a_two, a_neg;

    // 8-bit instance
    logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data;
    logic [3:0]  b_in_tag, b_out_tag;
    logic [2:0]  b_nz;
    logic [4:0]  b_one, b_two, b_neg;

    // 32-bit instance
    logic        c_in_valid, c_in_ready, c_in_signed, c_out_valid, c_out_ready;
    logic [31:0] c_in_data;
    logic [3:0]  c_in_tag, c_out_tag;
    logic [4:0]  c_nz;
    logic [16:0] c_one, c_two, c_neg;

    booth_r4_encoder_pipe #(.WIDTH(16), .TAG_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_signed(a_in_signed), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_one(a_one), .out_two(a_two), .out_neg(a_neg),
        .out_nz_cnt(a_nz), .out_tag(a_out_tag)
    );

    booth_r4_encoder_pipe #(.WIDTH(8), .TAG_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_signed(b_in_signed), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_one(b_one), .out_two(b_two), .out_neg(b_neg),
        .out_nz_cnt(b_nz), .out_tag(b_out_tag)
    );

    booth_r4_encoder_pipe #(.WIDTH(32), .TAG_W(4)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .in_signed(c_in_signed), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_one(c_one), .out_two(c_two), .out_neg(c_neg),
        .out_nz_cnt(c_nz), .out_tag(c_out_tag)
    );

    // ---------------- checking and reference model ----------------

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [16:0] one;
        logic [16:0] two;
        logic [16:0] neg;
        logic [7:0]  nz;
    } enc_t;

    typedef struct {
        logic [31:0] d;
        bit          s;
        logic [3:0]  tag;
        int          c;
    } txn_t;

    // Bit j of the extended operand: zero below bit 0, sign/zero fill above the MSB.
    function automatic int ext_bit(input logic [31:0] d, input int w, input bit s, input int j);
        if (j < 0) return 0;
        if (j >= w) return (s && d[w-1]) ? 1 : 0;
        return d[j] ? 1 : 0;
    endfunction

    // Digit value d_i = b[2i-1] + b[2i] - 2*b[2i+1], then split into magnitude/sign lines.
    function automatic enc_t ref_enc(input logic [31:0] d, input int w, input bit s);
        enc_t r;
        int   dig;
        r = '0;
        for (int i = 0; i < w / 2 + 1; i++) begin
            dig = ext_bit(d, w, s, 2*i-1) + ext_bit(d, w, s, 2*i) - 2 * ext_bit(d, w, s, 2*i+1);
            r.one[i] = (dig == 1) || (dig == -1);
            r.two[i] = (dig == 2) || (dig == -2);
            r.neg[i] = (dig < 0);
            if (dig != 0) r.nz = r.nz + 8'd1;
        end
        return r;
    endfunction

    function automatic longint op_value(input logic [31:0] d, input int w, input bit s);
        longint v = 0;
        for (int j = 0; j < w; j++) if (d[j]) v += longint'(1) << j;
        if (s && d[w-1]) v -= longint'(1) << w;
        return v;
    endfunction

    function automatic longint recon(input logic [16:0] one, input logic [16:0] two,
                                     input logic [16:0] neg, input int w);
        longint sum = 0;
        longint m;
        for (int i = 0; i < w / 2 + 1; i++) begin
            m = one[i] ? 1 : (two[i] ? 2 : 0);
            if (neg[i]) m = -m;
            sum += m * (longint'(1) << (2*i));
        end
        return sum;
    endfunction

    task automatic check_out(input string nm, input int w, input txn_t t,
                             input logic [16:0] one, input logic [16:0] two, input logic [16:0] neg,
                             input logic [7:0] nz, input logic [3:0] otag);
        enc_t r;
        r = ref_enc(t.d, w, t.s);
        check_val({nm, ".one"}, 64'(one), 64'(r.one));
        check_val({nm, ".two"}, 64'(two), 64'(r.two));
        check_val({nm, ".neg"}, 64'(neg), 64'(r.neg));
        check_val({nm, ".nz_cnt"}, 64'(nz), 64'(r.nz));
        check_val({nm, ".tag"}, 64'(otag), 64'(t.tag));
        check_val({nm, ".sum"}, 64'(recon(one, two, neg, w)), 64'(op_value(t.d, w, t.s)));
    endtask

    // ---------------- monitors (sample on falling edge) ----------------

    txn_t        qa[$], qb[$], qc[$];
    bit          a_stalled = 1'b0;
    logic [34:0] a_prev;

    always @(negedge clk) begin
        txn_t t;
        if (rst) begin
            qa.delete();
            a_stalled = 1'b0;
        end else begin
            check_val("a.in_ready", 64'(a_in_ready), 64'((qa.size() < 2) || a_out_ready));
            if (!a_out_valid)
                check_val("a.idle_zero", 64'({a_one, a_two, a_neg, a_nz, a_out_tag}), 64'd0);
            if (a_out_valid && a_stalled)
                check_val("a.stable", 64'({a_one, a_two, a_neg, a_nz, a_out_tag}), 64'(a_prev));
            a_stalled = a_out_valid && !a_out_ready;
            a_prev    = {a_one, a_two, a_neg, a_nz, a_out_tag};
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    check_val("a.spurious", 64'd1, 64'd0);
                end else begin
                    t = qa.pop_front();
                    check_out("a", 16, t, 17'(a_one), 17'(a_two), 17'(a_neg), 8'(a_nz), a_out_tag);
                    if (chk_lat) check_val("a.latency", 64'(cyc - t.c), 64'd2);
                end
            end
            if (a_in_valid && a_in_ready)
                qa.push_back('{d: 32'(a_in_data), s: a_in_signed, tag: a_in_tag, c: cyc});
        end
    end

    always @(negedge clk) begin
        txn_t t;
        if (rst) begin
            qb.delete();
        end else begin
            check_val("b.in_ready", 64'(b_in_ready), 64'((qb.size() < 2) || b_out_ready));
            if (!b_out_valid)
                check_val("b.idle_zero", 64'({b_one, b_two, b_neg, b_nz, b_out_tag}), 64'd0);
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    check_val("b.spurious", 64'd1, 64'd0);
                end else begin
                    t = qb.pop_front();
                    check_out("b", 8, t, 17'(b_one), 17'(b_two), 17'(b_neg), 8'(b_nz), b_out_tag);
                end
            end
            if (b_in_valid && b_in_ready)
                qb.push_back('{d: 32'(b_in_data), s: b_in_signed, tag: b_in_tag, c: cyc});
        end
    end

    always @(negedge clk) begin
        txn_t t;
        if (rst) begin
            qc.delete();
        end else begin
            check_val("c.in_ready", 64'(c_in_ready), 64'((qc.size() < 2) || c_out_ready));
            if (!c_out_valid)
                check_val("c.idle_zero", 64'({c_one, c_two, c_neg, c_nz, c_out_tag}), 64'd0);
            if (c_out_valid && c_out_ready) begin
                if (qc.size() == 0) begin
                    check_val("c.spurious", 64'd1, 64'd0);
                end else begin
                    t = qc.pop_front();
                    check_out("c", 32, t, c_one, c_two, c_neg, 8'(c_nz), c_out_tag);
                end
            end
            if (c_in_valid && c_in_ready)
                qc.push_back('{d: c_in_data, s: c_in_signed, tag: c_in_tag, c: cyc});
        end
    end

    // Random downstream backpressure during the regression phase.
    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            a_out_ready = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 3) != 0);
            c_out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- drivers (called at posedge+1, return at posedge+1) ----------------

    task automatic drive_a(input logic [15:0] d, input bit s, input logic [3:0] tag);
        int n = 0;
        a_in_valid = 1'b1; a_in_data = d; a_in_signed = s; a_in_tag = tag;
        do begin @(negedge clk); n++; end while (!a_in_ready && n < 100);
        if (!a_in_ready) check_val("a.accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic drive_b(input logic [7:0] d, input bit s, input logic [3:0] tag);
        int n = 0;
        b_in_valid = 1'b1; b_in_data = d; b_in_signed = s; b_in_tag = tag;
        do begin @(negedge clk); n++; end while (!b_in_ready && n < 100);
        if (!b_in_ready) check_val("b.accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drive_c(input logic [31:0] d, input bit s, input logic [3:0] tag);
        int n = 0;
        c_in_valid = 1'b1; c_in_data = d; c_in_signed = s; c_in_tag = tag;
        do begin @(negedge clk); n++; end while (!c_in_ready && n < 100);
        if (!c_in_ready) check_val("c.accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        c_in_valid = 1'b0;
    endtask

    task automatic drain_all();
        int n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 200) begin
            @(posedge clk); n++;
        end
        #1;
        check_val("drain_a", 64'(qa.size()), 64'd0);
        check_val("drain_b", 64'(qb.size()), 64'd0);
        check_val("drain_c", 64'(qc.size()), 64'd0);
    endtask

    // Corner-biased random operand of width w.
    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return m;
            2:       return 32'd1 << (w - 1);
            3:       return m >> 1;
            default: return $urandom() & m;
        endcase
    endfunction

    // ---------------- stimulus ----------------

    logic [15:0] dir_data [7];
    bit          dir_sgn  [7];

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_in_signed = 0; a_in_tag = '0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = '0; b_in_signed = 0; b_in_tag = '0; b_out_ready = 1;
        c_in_valid = 0; c_in_data = '0; c_in_signed = 0; c_in_tag = '0; c_out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // First cycle after reset release
        @(negedge clk);
        check_val("rst.in_ready", 64'(a_in_ready), 64'd1);
        check_val("rst.out_valid", 64'(a_out_valid), 64'd0);
        @(posedge clk); #1;

        // Directed operands, back-to-back with latency check
        dir_data = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h5555, 16'h5555};
        dir_sgn  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        chk_lat = 1'b1;
        for (int i = 0; i < 7; i++) drive_a(dir_data[i], dir_sgn[i], 4'(i));
        drain_all();
        chk_lat = 1'b0;
        @(posedge clk); #1;

        // Eight back-to-back operands with a 3-cycle downstream stall mid-stream
        fork
            begin
                repeat (3) @(posedge clk);
                #1 a_out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 a_out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++) drive_a(16'($urandom()), 1'($urandom_range(0, 1)), 4'(i));
        drain_all();
        @(posedge clk); #1;

        // Fill both stages, then reset with an input presented during reset
        a_out_ready = 1'b0;
        drive_a(16'h1234, 1'b1, 4'hA);
        drive_a(16'hBEEF, 1'b0, 4'hB);
        a_in_valid = 1'b1; a_in_data = 16'h7777; a_in_signed = 1'b1; a_in_tag = 4'hC;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        check_val("rstfull.out_valid", 64'(a_out_valid), 64'd0);
        check_val("rstfull.in_ready", 64'(a_in_ready), 64'd1);
        check_val("rstfull.outs", 64'({a_one, a_two, a_neg, a_nz, a_out_tag}), 64'd0);
        repeat (4) @(posedge clk);
        #1;

        // Randomized regression on all three widths with random backpressure
        rnd_on = 1'b1;
        fork
            for (int i = 0; i < 150; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                drive_a(16'(pick(16)), 1'($urandom_range(0, 1)), 4'($urandom()));
            end
            for (int i = 0; i < 150; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                drive_b(8'(pick(8)), 1'($urandom_range(0, 1)), 4'($urandom()));
            end
            for (int i = 0; i < 150; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                drive_c(pick(32), 1'($urandom_range(0, 1)), 4'($urandom()));
            end
        join
        rnd_on = 1'b0;
        @(posedge clk);
        #2;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
        drain_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
